// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares DMEM port B between NUM_REQ masters.
// Round-robin grant with burst lock and a MAX_BURST beat cap per grant.
// Memory-side outputs are registered. Read responses are routed back to the
// issuing requester RD_LAT cycles after mem_rden.
// Optional feature: define DMEM_ARB_FIXED_PRIO_EN to grant the lowest-index
// valid requester instead of rotating.
module dmem_port_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 16,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_wr,
    input  logic [NUM_REQ-1:0]          req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_wren,
    output logic                        mem_rden,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        busy
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        ST_IDLE,
        ST_OWNED
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     r_owner;
    logic [ID_W-1:0]     w_owner_nxt;
    logic [CNT_W-1:0]    r_beat_cnt;
    logic [CNT_W-1:0]    w_beat_nxt;
    logic [CNT_W-1:0]    w_beat_inc;
    logic                w_accept;
    logic                w_release;

    logic                w_grant_found;
    logic [ID_W-1:0]     w_grant_id;

    logic                w_own_valid;
    logic                w_own_wr;
    logic                w_own_lock;
    logic [ADDR_W-1:0]   w_own_addr;
    logic [DATA_W-1:0]   w_own_wdata;

    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_mem_wren;
    logic                r_mem_rden;
    logic [ID_W-1:0]     r_rd_id;

    logic [RD_LAT-1:0]   r_pipe_v;
    logic [ID_W-1:0]     r_pipe_id [RD_LAT];

`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]     r_last_owner;
    logic [31:0]         w_last_u;
    assign w_last_u = 32'(r_last_owner);
`endif

    // Select the current owner's request fields.
    always_comb begin
        w_own_valid = 1'b0;
        w_own_wr    = 1'b0;
        w_own_lock  = 1'b0;
        w_own_addr  = '0;
        w_own_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_owner == ID_W'(i)) begin
                w_own_valid = req_valid[i];
                w_own_wr    = req_wr[i];
                w_own_lock  = req_lock[i];
                w_own_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_own_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Choose the next owner among the valid requesters.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_id    = '0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!w_grant_found && req_valid[i]) begin
                w_grant_found = 1'b1;
                w_grant_id    = ID_W'(i);
            end
        end
`else
        // Scan offsets 1..NUM_REQ past the last owner so the previous owner
        // is considered last.
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!w_grant_found && req_valid[i] &&
                    (((w_last_u + k) % NUM_REQ) == i)) begin
                    w_grant_found = 1'b1;
                    w_grant_id    = ID_W'(i);
                end
            end
        end
`endif
    end

    assign w_beat_inc = r_beat_cnt + CNT_W'(1);

    // Next-state, acceptance and release decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_beat_nxt  = r_beat_cnt;
        w_accept    = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_found) begin
                    w_state_nxt = ST_OWNED;
                    w_owner_nxt = w_grant_id;
                end
            end
            ST_OWNED: begin
                if (w_own_valid) begin
                    w_accept   = 1'b1;
                    w_beat_nxt = w_beat_inc;
                    if (!w_own_lock || (w_beat_inc == CNT_W'(MAX_BURST))) begin
                        w_release = 1'b1;
                    end
                end else begin
                    w_release = 1'b1;
                end
                if (w_release) begin
                    w_state_nxt = ST_IDLE;
                    w_beat_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_beat_nxt  = '0;
            end
        endcase
    end

    // State, owner and beat counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_owner    <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_beat_cnt <= w_beat_nxt;
        end
    end

`ifndef DMEM_ARB_FIXED_PRIO_EN
    // Remember who held the port last so the rotation moves past them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_owner <= ID_W'(NUM_REQ - 1);
        end else if (w_release) begin
            r_last_owner <= r_owner;
        end
    end
`endif

    // Register the accepted beat onto the memory port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wren  <= 1'b0;
            r_mem_rden  <= 1'b0;
            r_rd_id     <= '0;
        end else begin
            r_mem_wren <= w_accept & w_own_wr;
            r_mem_rden <= w_accept & ~w_own_wr;
            if (w_accept) begin
                r_mem_addr  <= w_own_addr;
                r_mem_wdata <= w_own_wdata;
                r_rd_id     <= r_owner;
            end
        end
    end

    // Track outstanding reads so each response returns to its issuer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_v <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                r_pipe_id[i] <= '0;
            end
        end else begin
            r_pipe_v[0]  <= r_mem_rden;
            r_pipe_id[0] <= r_rd_id;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                r_pipe_v[i]  <= r_pipe_v[i-1];
                r_pipe_id[i] <= r_pipe_id[i-1];
            end
        end
    end

    // Decode ready and response strobes from registered state only.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if ((r_state == ST_OWNED) && (r_owner == ID_W'(i))) begin
                req_ready[i] = 1'b1;
            end
            if (r_pipe_v[RD_LAT-1] && (r_pipe_id[RD_LAT-1] == ID_W'(i))) begin
                rsp_valid[i] = 1'b1;
            end
        end
    end

    assign rsp_rdata = r_pipe_v[RD_LAT-1] ? mem_rdata : '0;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wren  = r_mem_wren;
    assign mem_rden  = r_mem_rden;
    assign busy      = (r_state == ST_OWNED) | r_mem_rden | (|r_pipe_v);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed testbench for dmem_port_arbiter with a behavioural port-B RAM.
// Built with NUM_REQ=2, RD_LAT=2, MAX_BURST=4.
module tb_dmem_port_arbiter;

    localparam int NR = 2;
    localparam int AW = 11;
    localparam int DW = 16;
    localparam int RL = 2;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_wr;
    logic [NR-1:0]     req_lock;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_wren;
    logic              mem_rden;
    logic [DW-1:0]     mem_rdata;
    logic              busy;

    int n_pass  = 0;
    int n_total = 0;

    dmem_port_arbiter #(
        .NUM_REQ   (NR),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .RD_LAT    (RL),
        .MAX_BURST (MB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_wr    (req_wr),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wren  (mem_wren),
        .mem_rden  (mem_rden),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // RAM model: write-then-read ordering, RL-cycle read latency.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] q_pipe [0:RL-1];
    logic          pl_we = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_we) ram[pl_addr] <= pl_data;
        else if (mem_wren) ram[mem_addr] <= mem_wdata;
        q_pipe[0] <= mem_rden ? ram[mem_addr] : 16'hDEAD;
        for (int i = 1; i < RL; i++) q_pipe[i] <= q_pipe[i-1];
    end
    assign mem_rdata = q_pipe[RL-1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        step();
        pl_we = 1'b0;
    endtask

    task automatic set_req(input int i, input logic v, input logic wr, input logic lk,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i] = v;
        req_wr[i]    = wr;
        req_lock[i]  = lk;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_reqs();
        req_valid = '0; req_wr = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic do_reset();
        clear_reqs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_reqs();
        rst = 1'b1;
        step();
        step();
        n_total++; if (req_ready !== 2'b00) $display("FAIL rst_ready: got %b exp 00", req_ready); else n_pass++;
        n_total++; if (rsp_valid !== 2'b00) $display("FAIL rst_rsp_valid: got %b exp 00", rsp_valid); else n_pass++;
        n_total++; if (rsp_rdata !== 16'h0) $display("FAIL rst_rsp_rdata: got %h exp 0000", rsp_rdata); else n_pass++;
        n_total++; if (mem_addr !== 11'h0) $display("FAIL rst_mem_addr: got %h exp 000", mem_addr); else n_pass++;
        n_total++; if (mem_wdata !== 16'h0) $display("FAIL rst_mem_wdata: got %h exp 0000", mem_wdata); else n_pass++;
        n_total++; if (mem_wren !== 1'b0) $display("FAIL rst_mem_wren: got %b exp 0", mem_wren); else n_pass++;
        n_total++; if (mem_rden !== 1'b0) $display("FAIL rst_mem_rden: got %b exp 0", mem_rden); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else n_pass++;
        rst = 1'b0;
        step();
        n_total++; if (req_ready !== 2'b00) $display("FAIL idle_ready: got %b exp 00", req_ready); else n_pass++;
    endtask

    task automatic test_single_write();
        // c0: write request from requester 0
        set_req(0, 1'b1, 1'b1, 1'b0, 11'h012, 16'hBEEF);
        step(); // c1
        n_total++; if (req_ready !== 2'b01) $display("FAIL sw_ready: got %b exp 01", req_ready); else n_pass++;
        step(); // c2
        set_req(0, 1'b0, 1'b0, 1'b0, 11'h000, 16'h0000);
        n_total++; if (mem_wren !== 1'b1) $display("FAIL sw_wren: got %b exp 1", mem_wren); else n_pass++;
        n_total++; if (mem_rden !== 1'b0) $display("FAIL sw_rden: got %b exp 0", mem_rden); else n_pass++;
        n_total++; if (mem_addr !== 11'h012) $display("FAIL sw_addr: got %h exp 012", mem_addr); else n_pass++;
        n_total++; if (mem_wdata !== 16'hBEEF) $display("FAIL sw_wdata: got %h exp beef", mem_wdata); else n_pass++;
        n_total++; if (req_ready !== 2'b00) $display("FAIL sw_release: got %b exp 00", req_ready); else n_pass++;
        step(); // c3
        n_total++; if (mem_wren !== 1'b0) $display("FAIL sw_wren_pulse: got %b exp 0", mem_wren); else n_pass++;
        set_req(0, 1'b1, 1'b0, 1'b0, 11'h012, 16'h0000);
        step(); // c4: read accepted here
        n_total++; if (req_ready !== 2'b01) $display("FAIL sr_ready: got %b exp 01", req_ready); else n_pass++;
        step(); // c5
        set_req(0, 1'b0, 1'b0, 1'b0, 11'h000, 16'h0000);
        n_total++; if (mem_rden !== 1'b1) $display("FAIL sr_rden: got %b exp 1", mem_rden); else n_pass++;
        n_total++; if (mem_wren !== 1'b0) $display("FAIL sr_wren: got %b exp 0", mem_wren); else n_pass++;
        step(); // c6
        n_total++; if (rsp_valid !== 2'b00) $display("FAIL sr_rsp_early: got %b exp 00", rsp_valid); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL sr_busy: got %b exp 1", busy); else n_pass++;
        step(); // c7 = accept + 1 + RL
        n_total++; if (rsp_valid !== 2'b01) $display("FAIL sr_rsp_valid: got %b exp 01", rsp_valid); else n_pass++;
        n_total++; if (rsp_rdata !== 16'hBEEF) $display("FAIL sr_rsp_rdata: got %h exp beef", rsp_rdata); else n_pass++;
        step(); // c8
        n_total++; if (rsp_valid !== 2'b00) $display("FAIL sr_rsp_once: got %b exp 00", rsp_valid); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_ready [8];
        logic [1:0]  exp_rsp   [8];
        logic [15:0] exp_data  [8];
        do_reset();
        preload(11'h020, 16'hA0A0);
        preload(11'h021, 16'hA1A1);
`ifdef DMEM_ARB_FIXED_PRIO_EN
        exp_ready = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
        exp_rsp   = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
        exp_data  = '{16'h0, 16'h0, 16'h0, 16'hA0A0, 16'h0, 16'hA0A0, 16'h0, 16'hA0A0};
`else
        exp_ready = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        exp_rsp   = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
        exp_data  = '{16'h0, 16'h0, 16'h0, 16'hA0A0, 16'h0, 16'hA1A1, 16'h0, 16'hA0A0};
`endif
        set_req(0, 1'b1, 1'b0, 1'b0, 11'h020, 16'h0);
        set_req(1, 1'b1, 1'b0, 1'b0, 11'h021, 16'h0);
        for (int c = 0; c < 8; c++) begin
            step();
            n_total++;
            if (req_ready !== exp_ready[c]) $display("FAIL rr_ready c%0d: got %b exp %b", c+1, req_ready, exp_ready[c]);
            else n_pass++;
            n_total++;
            if (rsp_valid !== exp_rsp[c]) $display("FAIL rr_rsp_valid c%0d: got %b exp %b", c+1, rsp_valid, exp_rsp[c]);
            else n_pass++;
            n_total++;
            if (rsp_rdata !== exp_data[c]) $display("FAIL rr_rsp_rdata c%0d: got %h exp %h", c+1, rsp_rdata, exp_data[c]);
            else n_pass++;
        end
        clear_reqs();
        repeat (4) step();
    endtask

    task automatic test_burst_cap();
        logic [1:0]  exp_ready [8];
        logic        exp_wren  [8];
        logic [10:0] exp_addr  [8];
        logic [15:0] exp_wdata [8];
        logic [10:0] a1;
        do_reset();
        exp_ready = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        exp_wren  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_addr  = '{11'h0, 11'h100, 11'h101, 11'h102, 11'h103, 11'h0, 11'h050, 11'h0};
        exp_wdata = '{16'h0, 16'h7100, 16'h7101, 16'h7102, 16'h7103, 16'h0, 16'h5050, 16'h0};
        // c0: only requester 1, locked writes
        set_req(1, 1'b1, 1'b1, 1'b1, 11'h100, 16'h7100);
        for (int c = 1; c <= 8; c++) begin
            step();
            a1 = 11'h100 + 11'((c - 1 < 4) ? c - 1 : 4);
            set_req(1, 1'b1, 1'b1, 1'b1, a1, 16'h7000 + 16'(a1));
            if (c <= 6) set_req(0, 1'b1, 1'b1, 1'b0, 11'h050, 16'h5050);
            else        set_req(0, 1'b0, 1'b0, 1'b0, 11'h000, 16'h0000);
            n_total++;
            if (req_ready !== exp_ready[c-1]) $display("FAIL bc_ready c%0d: got %b exp %b", c, req_ready, exp_ready[c-1]);
            else n_pass++;
            n_total++;
            if (mem_wren !== exp_wren[c-1]) $display("FAIL bc_wren c%0d: got %b exp %b", c, mem_wren, exp_wren[c-1]);
            else n_pass++;
            if (exp_wren[c-1]) begin
                n_total++;
                if (mem_addr !== exp_addr[c-1]) $display("FAIL bc_addr c%0d: got %h exp %h", c, mem_addr, exp_addr[c-1]);
                else n_pass++;
                n_total++;
                if (mem_wdata !== exp_wdata[c-1]) $display("FAIL bc_wdata c%0d: got %h exp %h", c, mem_wdata, exp_wdata[c-1]);
                else n_pass++;
            end
        end
        clear_reqs();
        repeat (3) step();
    endtask

    task automatic test_read_pipeline();
        logic        exp_rden [7];
        logic [1:0]  exp_rsp  [7];
        logic [15:0] exp_data [7];
        logic        exp_busy [7];
        do_reset();
        preload(11'h000, 16'h1111);
        preload(11'h001, 16'h2222);
        preload(11'h002, 16'h3333);
        exp_rden = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_rsp  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
        exp_data = '{16'h0, 16'h0, 16'h0, 16'h1111, 16'h2222, 16'h3333, 16'h0};
        exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        set_req(0, 1'b1, 1'b0, 1'b1, 11'h000, 16'h0);
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c <= 3) set_req(0, 1'b1, 1'b0, 1'b1, 11'(c - 1), 16'h0);
            else        set_req(0, 1'b0, 1'b0, 1'b0, 11'h000, 16'h0);
            n_total++;
            if (mem_rden !== exp_rden[c-1]) $display("FAIL rp_rden c%0d: got %b exp %b", c, mem_rden, exp_rden[c-1]);
            else n_pass++;
            n_total++;
            if (rsp_valid !== exp_rsp[c-1]) $display("FAIL rp_rsp_valid c%0d: got %b exp %b", c, rsp_valid, exp_rsp[c-1]);
            else n_pass++;
            n_total++;
            if (rsp_rdata !== exp_data[c-1]) $display("FAIL rp_rsp_rdata c%0d: got %h exp %h", c, rsp_rdata, exp_data[c-1]);
            else n_pass++;
            n_total++;
            if (busy !== exp_busy[c-1]) $display("FAIL rp_busy c%0d: got %b exp %b", c, busy, exp_busy[c-1]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        // c0: locked read burst from requester 0
        set_req(0, 1'b1, 1'b0, 1'b1, 11'h000, 16'h0);
        step(); // c1: first beat accepted
        set_req(0, 1'b1, 1'b0, 1'b1, 11'h001, 16'h0);
        step(); // c2: second beat presented, reset asserted
        n_total++; if (mem_rden !== 1'b1) $display("FAIL rm_first_rden: got %b exp 1", mem_rden); else n_pass++;
        rst = 1'b1;
        step(); // c3
        rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 1'b0, 11'h002, 16'h0);
        set_req(1, 1'b1, 1'b0, 1'b0, 11'h001, 16'h0);
        n_total++; if (req_ready !== 2'b00) $display("FAIL rm_ready: got %b exp 00", req_ready); else n_pass++;
        n_total++; if (rsp_valid !== 2'b00) $display("FAIL rm_rsp_valid: got %b exp 00", rsp_valid); else n_pass++;
        n_total++; if (rsp_rdata !== 16'h0) $display("FAIL rm_rsp_rdata: got %h exp 0000", rsp_rdata); else n_pass++;
        n_total++; if (mem_addr !== 11'h0) $display("FAIL rm_addr: got %h exp 000", mem_addr); else n_pass++;
        n_total++; if (mem_rden !== 1'b0) $display("FAIL rm_rden: got %b exp 0", mem_rden); else n_pass++;
        n_total++; if (mem_wren !== 1'b0) $display("FAIL rm_wren: got %b exp 0", mem_wren); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rm_busy: got %b exp 0", busy); else n_pass++;
        step(); // c4: stale response from c1 would land here
        n_total++; if (req_ready !== 2'b01) $display("FAIL rm_post_grant: got %b exp 01", req_ready); else n_pass++;
        n_total++; if (rsp_valid !== 2'b00) $display("FAIL rm_stale_c4: got %b exp 00", rsp_valid); else n_pass++;
        step(); // c5
        clear_reqs();
        n_total++; if (rsp_valid !== 2'b00) $display("FAIL rm_stale_c5: got %b exp 00", rsp_valid); else n_pass++;
        step(); // c6
        n_total++; if (rsp_valid !== 2'b00) $display("FAIL rm_stale_c6: got %b exp 00", rsp_valid); else n_pass++;
        step(); // c7: read accepted at c4 returns
        n_total++; if (rsp_valid !== 2'b01) $display("FAIL rm_new_rsp: got %b exp 01", rsp_valid); else n_pass++;
        n_total++; if (rsp_rdata !== 16'h3333) $display("FAIL rm_new_rdata: got %h exp 3333", rsp_rdata); else n_pass++;
        step();
    endtask

    initial begin
        clear_reqs();
        rst = 1'b1;
        test_reset();
        test_single_write();
        test_round_robin();
        test_burst_cap();
        test_read_pipeline();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Parametrised N-requester arbiter for the shared port B of the dual-port DMEM block RAM.
- Replaces the hard-wired CCD connection on that port so the CCD writer, the NN accelerator and further masters can share it.
- Round-robin grant with optional burst lock and a per-grant beat cap.
- Registered memory-side outputs; per-requester read-response routing that tracks the RAM read latency.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 11, DMEM word address width.
- DATA_W, 16, DMEM data width.
- RD_LAT, 1, RAM read latency in cycles from mem_rden to valid mem_rdata (1..4).
- MAX_BURST, 16, max beats per grant before forced rotation (power of 2, ≥1).

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  request beat valid, per requester
- req_wr  in  NUM_REQ  1=write, 0=read
- req_lock  in  NUM_REQ  hold grant after this beat (burst continuation)
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing
- req_ready  out  NUM_REQ  beat accepted when valid&ready
- rsp_valid  out  NUM_REQ  read data valid for requester i
- rsp_rdata  out  DATA_W  shared read data bus
- mem_addr  out  ADDR_W  to RAM address_b
- mem_wdata  out  DATA_W  to RAM data_b
- mem_wren  out  1  to RAM wren_b
- mem_rden  out  1  to RAM rden_b
- mem_rdata  in  DATA_W  from RAM q_b
- busy  out  1  high in OWNED state or while any read is in flight

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values:
  - All outputs 0. State IDLE. last_owner = NUM_REQ-1, so requester 0 has first priority.
  - Beat counter 0. Response pipeline cleared.
  - Reset mid-burst or mid-read drops everything: no rsp_valid is produced for reads already issued.
- State machine: IDLE, OWNED.
- IDLE:
  - req_ready all 0.
  - If any req_valid: owner = first valid index searching from last_owner+1 with wrap-around at NUM_REQ; go to OWNED.
  - Arbitration costs one cycle.
- OWNED:
  - req_ready[owner] = 1 (decoded from registered state/owner only); all other ready bits 0.
  - Accepted beat (req_valid[owner]) registers mem_addr/mem_wdata and pulses mem_wren = req_wr or mem_rden = ~req_wr for exactly 1 cycle, on the cycle after acceptance.
  - mem_wren and mem_rden are never high together.
  - No accepted beat: both strobes low; address/data hold their last values.
- Release from OWNED to IDLE (last_owner = owner, beat counter cleared), on any of:
  - (a) beat accepted with req_lock[owner]=0;
  - (b) req_valid[owner]=0 in an OWNED cycle;
  - (c) beat accepted and beat count reaches MAX_BURST, regardless of lock.
- Beat counter: width $clog2(MAX_BURST)+1. Increments per accepted beat. Never wraps, because (c) releases first.
- Read response:
  - A shift pipeline of depth RD_LAT carries {valid, owner id}, launched with mem_rden.
  - rsp_valid[id] rises exactly RD_LAT cycles after mem_rden. rsp_rdata = mem_rdata in that cycle, registered if needed to keep alignment.
  - End-to-end read latency from acceptance to rsp_valid = 1 + RD_LAT cycles.
  - Pipelined back-to-back reads produce one rsp_valid per cycle, in order.
  - Responses complete after a grant releases. A new owner's reads never collide with them, because each pipeline slot holds one id.
- Writes have no response. A write accepted on cycle N is visible to a read accepted on cycle N+1 (RAM read-during-write returns new data is required of the RAM config; the arbiter preserves issue order).
- Simultaneous events:
  - New requests arriving during OWNED wait; they are never dropped.
  - The owner re-asserting valid in the release cycle is not granted back-to-back if another requester is valid, because round-robin moves past it.

Optional Feature:
- Macro DMEM_ARB_FIXED_PRIO_EN.
- Defined: IDLE grants the lowest-index valid requester; last_owner is ignored. Lock and MAX_BURST still apply.
- Undefined: round-robin as above.

Test Plan:
- Single write: req 0 writes addr 0x012, data 0xBEEF, lock=0 → ready[0] on cycle 1, mem_wren=1/mem_addr=0x012/mem_wdata=0xBEEF on cycle 2, back to IDLE; a later read of 0x012 gives rsp_valid[0] with rsp_rdata=0xBEEF at accept+1+RD_LAT.
- Round-robin: req 0 and req 1 valid continuously with single-beat reads → grants alternate 0,1,0,1; each owner gets one beat per grant.
- Burst cap: MAX_BURST=4, req 1 holds valid and lock=1 for 10 writes while req 0 waits → req 1 gets 4 beats, then req 0 is granted, then req 1 resumes.
- Read pipeline: RD_LAT=2, req 0 issues 3 locked reads to 0x000..0x002 preloaded with 0x1111/0x2222/0x3333 → rsp_valid[0] high 3 consecutive cycles with that data in order; rsp_valid[1] stays 0.
- Reset mid-burst: assert rst during the second beat of a locked read burst → next cycle all outputs 0, no stale rsp_valid afterwards, req 0 wins the first post-reset arbitration.
- With DMEM_ARB_FIXED_PRIO_EN: req 0 and req 1 valid continuously with single beats → req 0 granted every time, req 1 starves.
